adc_sample_capture: RTL and testbench

Capture side of the panel readout path. Consumes the per-pixel ADC start trigger and row/column address produced by the frame timing generator, runs the conversion handshake with the external ADC, tags each sample with its pixel address and a start-of-frame flag, and buffers it in a small FIFO that drains over a valid/ready stream toward the frame packer.

---
 rtl/adc_sample_capture.sv | 221 ++++++++++++++++++++++
 tb/tb_adc_sample_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_capture.sv
// Purpose : capture FIFO for tagged ADC samples, drained over a valid/ready stream.
// Latency : push at edge M -> head visible (o_vld) from cycle M+1; pop removes head at the accepting edge.
// Backpr. : caller must only push when not full or when popping in the same cycle.
module adc_capture_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    output logic         o_full,
    input  logic         i_pop,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_full    = (r_count == FULL_CNT);
    assign o_vld     = (r_count != '0);
    assign w_do_pop  = i_pop && o_vld;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Gate the head so an empty FIFO presents zeros rather than stale data.
    assign o_dat     = o_vld ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

// Purpose : runs the ADC conversion handshake per pixel trigger, tags samples with address/SOF, buffers them.
// Latency : trigger edge N -> adc_conv N+1..N+CONV_CYCLES; data edge M -> word on stream from M+1.
// Backpr. : m_ready low holds the head stable; a sample arriving to a full FIFO is dropped (err_overflow).
// Ports   : i_frame_start/i_adc_start_trigger/i_row_addr/i_col_addr from timing generator;
//           o_adc_conv/i_adc_data_valid/i_adc_data to the ADC; o_m_* stream to packer;
//           o_busy/o_sample_count/o_err_* status.
module adc_sample_capture #(
    parameter int DATA_W         = 14,
    parameter int FIFO_DEPTH     = 16,
    parameter int CONV_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    input  logic              i_adc_start_trigger,
    input  logic [11:0]       i_row_addr,
    input  logic [11:0]       i_col_addr,
    output logic              o_adc_conv,
    input  logic              i_adc_data_valid,
    input  logic [DATA_W-1:0] i_adc_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic [11:0]       o_m_row,
    output logic [11:0]       o_m_col,
    output logic              o_m_sof,
    output logic              o_busy,
    output logic [23:0]       o_sample_count,
    output logic              o_err_overflow,
    output logic              o_err_timeout,
    output logic              o_err_trig_overrun
);
    localparam int WORD_W = 1 + 12 + 12 + DATA_W;
    localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_WAIT_DATA} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_conv_cnt;
    logic [TW-1:0]       r_to_cnt;
    logic [11:0]         r_row;
    logic [11:0]         r_col;
    logic                r_sof_pending;
    logic [23:0]         r_sample_count;
    logic                r_err_overflow;
    logic                r_err_timeout;
    logic                r_err_trig_overrun;

    logic                w_conv_done;
    logic                w_to_hit;
    logic                w_accept_trig;
    logic                w_trig_overrun;
    logic                w_wr_req;
    logic                w_wr_ok;
    logic                w_timeout;
    logic                w_fifo_full;
    logic                w_pop;
    logic [WORD_W-1:0]   w_push_dat;
    logic [WORD_W-1:0]   w_pop_dat;

    assign w_conv_done = (r_conv_cnt == CONV_LAST);
    assign w_to_hit    = (r_to_cnt == TO_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state; frame_start aborts any conversion in flight
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (i_adc_start_trigger) w_state_nxt = S_CONVERT;
            S_CONVERT:   if (i_frame_start) w_state_nxt = S_IDLE;
                         else if (w_conv_done) w_state_nxt = S_WAIT_DATA;
            S_WAIT_DATA: if (i_frame_start || i_adc_data_valid || w_to_hit) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // State-derived outputs and events
    always_comb begin
        o_adc_conv     = (r_state == S_CONVERT);
        o_busy         = (r_state != S_IDLE);
        w_accept_trig  = (r_state == S_IDLE) && i_adc_start_trigger;
        w_trig_overrun = (r_state != S_IDLE) && i_adc_start_trigger;
        w_wr_req       = (r_state == S_WAIT_DATA) && i_adc_data_valid && !i_frame_start;
        w_timeout      = (r_state == S_WAIT_DATA) && w_to_hit && !i_adc_data_valid && !i_frame_start;
    end

    assign w_pop   = o_m_valid && i_m_ready;
    assign w_wr_ok = w_wr_req && (!w_fifo_full || w_pop);

    // Cycle counters restart on every entry into their state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_conv_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_conv_cnt <= (r_state == S_CONVERT && !w_conv_done) ? r_conv_cnt + 1'b1 : '0;
            r_to_cnt   <= (r_state == S_WAIT_DATA && !w_to_hit) ? r_to_cnt + 1'b1 : '0;
        end
    end

    // Address latch, SOF tagging, sample counter and sticky errors
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row              <= '0;
            r_col              <= '0;
            r_sof_pending      <= 1'b1;
            r_sample_count     <= '0;
            r_err_overflow     <= 1'b0;
            r_err_timeout      <= 1'b0;
            r_err_trig_overrun <= 1'b0;
        end else begin
            if (w_accept_trig) begin
                r_row <= i_row_addr;
                r_col <= i_col_addr;
            end
            if (i_frame_start) begin
                r_sof_pending      <= 1'b1;
                r_sample_count     <= '0;
                r_err_overflow     <= 1'b0;
                r_err_timeout      <= 1'b0;
                r_err_trig_overrun <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    r_sof_pending  <= 1'b0;
                    r_sample_count <= r_sample_count + 24'd1;
                end
                if (w_wr_req && !w_wr_ok) r_err_overflow     <= 1'b1;
                if (w_timeout)            r_err_timeout      <= 1'b1;
                if (w_trig_overrun)       r_err_trig_overrun <= 1'b1;
            end
        end
    end

    assign w_push_dat = {r_sof_pending, r_row, r_col, i_adc_data};

    adc_capture_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (w_wr_ok),
        .i_push_dat (w_push_dat),
        .o_full     (w_fifo_full),
        .i_pop      (w_pop),
        .o_vld      (o_m_valid),
        .o_dat      (w_pop_dat)
    );

    assign {o_m_sof, o_m_row, o_m_col, o_m_data} = w_pop_dat;

    assign o_sample_count     = r_sample_count;
    assign o_err_overflow     = r_err_overflow;
    assign o_err_timeout      = r_err_timeout;
    assign o_err_trig_overrun = r_err_trig_overrun;
endmodule

// File: tb/tb_adc_sample_capture.sv
module tb_adc_sample_capture;
    localparam int DATA_W = 14;
    localparam int DEPTH  = 16;
    localparam int CONV   = 4;
    localparam int TO     = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              trig = 1'b0;
    logic [11:0]       row = '0;
    logic [11:0]       col = '0;
    logic              dv = 1'b0;
    logic [DATA_W-1:0] dat = '0;
    logic              m_ready = 1'b0;

    logic              adc_conv, m_valid, m_sof, busy;
    logic [DATA_W-1:0] m_data;
    logic [11:0]       m_row, m_col;
    logic [23:0]       sample_count;
    logic              err_ovf, err_to, err_ovr;

    always #5 clk = ~clk;

    adc_sample_capture #(
        .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CONV_CYCLES(CONV), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
        .i_adc_start_trigger(trig), .i_row_addr(row), .i_col_addr(col),
        .o_adc_conv(adc_conv), .i_adc_data_valid(dv), .i_adc_data(dat),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_m_row(m_row), .o_m_col(m_col), .o_m_sof(m_sof), .o_busy(busy),
        .o_sample_count(sample_count), .o_err_overflow(err_ovf),
        .o_err_timeout(err_to), .o_err_trig_overrun(err_ovr)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              sof;
        logic [11:0]       row;
        logic [11:0]       col;
        logic [DATA_W-1:0] data;
    } word_t;

    word_t       q[$];
    logic [23:0] e_cnt = '0;
    logic        e_ovf = 1'b0, e_to = 1'b0, e_ovr = 1'b0, e_sof = 1'b1;

    // Events announced by the stimulus for the edge that follows
    logic              push_req = 1'b0;
    logic [11:0]       push_row = '0, push_col = '0;
    logic [DATA_W-1:0] push_dat = '0;
    logic              to_evt = 1'b0, ovr_evt = 1'b0;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        bit    pop;
        word_t w;
        if (!rst_n) begin
            q.delete();
            e_cnt = '0; e_ovf = 1'b0; e_to = 1'b0; e_ovr = 1'b0; e_sof = 1'b1;
        end else begin
            pop = (q.size() != 0) && m_ready;
            if (frame_start) begin
                e_cnt = '0; e_ovf = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
            end
            if (push_req) begin
                if (q.size() < DEPTH || pop) begin
                    w.sof = e_sof; w.row = push_row; w.col = push_col; w.data = push_dat;
                    q.push_back(w);
                    e_cnt = e_cnt + 24'd1;
                    e_sof = 1'b0;
                end else begin
                    e_ovf = 1'b1;
                end
            end
            if (to_evt)  e_to  = 1'b1;
            if (ovr_evt) e_ovr = 1'b1;
            if (frame_start) e_sof = 1'b1;
            if (pop) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("m_valid", m_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("m_data", m_data, q[0].data);
                chk("m_row",  m_row,  q[0].row);
                chk("m_col",  m_col,  q[0].col);
                chk("m_sof",  m_sof,  q[0].sof);
            end
            chk("sample_count", sample_count, e_cnt);
            chk("err_overflow", err_ovf, e_ovf);
            chk("err_timeout",  err_to,  e_to);
            chk("err_trig_overrun", err_ovr, e_ovr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger_pixel(input logic [11:0] r, input logic [11:0] c, input bit fs);
        trig = 1'b1; row = r; col = c; frame_start = fs;
        step();
        trig = 1'b0; frame_start = 1'b0;
    endtask

    task automatic conv_check();
        for (int i = 0; i < CONV; i++) begin
            chk("adc_conv_hi", adc_conv, 1'b1);
            chk("busy_conv", busy, 1'b1);
            step();
        end
        chk("adc_conv_lo", adc_conv, 1'b0);
        chk("busy_wait", busy, 1'b1);
    endtask

    task automatic respond(input logic [11:0] r, input logic [11:0] c,
                           input logic [DATA_W-1:0] d, input int lat, input bit pop_with);
        bit keep_ready;
        for (int i = 0; i < lat; i++) begin
            chk("busy_wait", busy, 1'b1);
            step();
        end
        keep_ready = m_ready;
        dv = 1'b1; dat = d;
        push_req = 1'b1; push_row = r; push_col = c; push_dat = d;
        if (pop_with) m_ready = 1'b1;
        step();
        dv = 1'b0; push_req = 1'b0; m_ready = keep_ready;
        chk("busy_done", busy, 1'b0);
    endtask

    task automatic pixel(input logic [11:0] r, input logic [11:0] c,
                         input logic [DATA_W-1:0] d, input int lat, input bit fs, input bit pop_with);
        trigger_pixel(r, c, fs);
        conv_check();
        respond(r, c, d, lat, pop_with);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_adc_conv", adc_conv, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 14'h0);
        chk("rst_count", sample_count, 24'h0);
        chk("rst_errs", {err_ovf, err_to, err_ovr}, 3'b000);
        step();
        rst_n = 1'b1;
        step();
        cmp_en = 1'b1;

        // Single pixel with SOF
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        pixel(12'd5, 12'd7, 14'h1ABC, 3, 1'b0, 1'b0);
        chk("t1_m_valid", m_valid, 1'b1);
        chk("t1_m_data", m_data, 14'h1ABC);
        chk("t1_m_row", m_row, 12'd5);
        chk("t1_m_col", m_col, 12'd7);
        chk("t1_m_sof", m_sof, 1'b1);
        chk("t1_count", sample_count, 24'd1);
        m_ready = 1'b1;
        step();
        chk("t1_drained", m_valid, 1'b0);

        // Row of 8 pixels at 200-cycle spacing; first trigger coincides with frame_start
        for (int k = 0; k < 8; k++) begin
            pixel(12'd5, 12'(k), 14'(14'h100 + k), k % 4, k == 0, 1'b0);
            repeat (200 - (CONV + (k % 4) + 2)) step();
        end
        chk("t2_count", sample_count, 24'd8);
        chk("t2_errs", {err_ovf, err_to, err_ovr}, 3'b000);

        // Overflow: 17 conversions with the stream stalled
        m_ready = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            pixel(12'd7, 12'(k), 14'(14'h200 + k), 0, 1'b0, 1'b0);
            step();
        end
        chk("t3_overflow", err_ovf, 1'b1);
        chk("t3_count", sample_count, 24'd16);
        // Full FIFO accepts a write when the head pops on the same edge
        pixel(12'd7, 12'd99, 14'h2FFF, 1, 1'b0, 1'b1);
        chk("t3_count_pop", sample_count, 24'd17);
        m_ready = 1'b1;
        repeat (20) step();
        chk("t3_drained", m_valid, 1'b0);
        m_ready = 1'b0;

        // ADC never responds
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        trigger_pixel(12'd1, 12'd1, 1'b0);
        conv_check();
        for (int i = 0; i < TO; i++) begin
            chk("t4_to_early", err_to, 1'b0);
            chk("t4_busy", busy, 1'b1);
            if (i == TO - 1) to_evt = 1'b1;
            step();
            to_evt = 1'b0;
        end
        chk("t4_timeout", err_to, 1'b1);
        chk("t4_idle", busy, 1'b0);
        chk("t4_no_word", m_valid, 1'b0);
        pixel(12'd1, 12'd2, 14'h0055, 0, 1'b0, 1'b0);
        chk("t4_next_data", m_data, 14'h0055);

        // Trigger during CONVERT
        trigger_pixel(12'd9, 12'd9, 1'b0);
        chk("t5_conv", adc_conv, 1'b1);
        trig = 1'b1; row = 12'd100; col = 12'd200; ovr_evt = 1'b1;
        step();
        trig = 1'b0; ovr_evt = 1'b0;
        chk("t5_overrun", err_ovr, 1'b1);
        for (int i = 1; i < CONV; i++) begin
            chk("t5_conv_hold", adc_conv, 1'b1);
            step();
        end
        chk("t5_conv_end", adc_conv, 1'b0);
        respond(12'd9, 12'd9, 14'h0999, 2, 1'b0);

        // frame_start mid-WAIT_DATA
        trigger_pixel(12'd3, 12'd3, 1'b0);
        conv_check();
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t6_abort_idle", busy, 1'b0);
        chk("t6_errs_clr", {err_ovf, err_to, err_ovr}, 3'b000);
        chk("t6_fifo_kept", m_valid, 1'b1);
        dv = 1'b1; dat = 14'h3333;
        step();
        dv = 1'b0;
        chk("t6_late_ignored", sample_count, 24'd0);

        // Asynchronous reset mid-WAIT_DATA
        trigger_pixel(12'd4, 12'd4, 1'b0);
        conv_check();
        step();
        rst_n = 1'b0;
        #1;
        chk("t7_adc_conv", adc_conv, 1'b0);
        chk("t7_busy", busy, 1'b0);
        chk("t7_m_valid", m_valid, 1'b0);
        chk("t7_m_fields", {m_data, m_row, m_col, m_sof}, 39'h0);
        chk("t7_count", sample_count, 24'h0);
        chk("t7_errs", {err_ovf, err_to, err_ovr}, 3'b000);
        step();
        step();
        rst_n = 1'b1;
        step();
        m_ready = 1'b1;
        pixel(12'd3, 12'd4, 14'h2222, 1, 1'b0, 1'b0);
        chk("t7_sof_after_rst", m_sof, 1'b1);
        chk("t7_data_after_rst", m_data, 14'h2222);
        repeat (3) step();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
